// File: rtl/tft_cmd_queue_if.sv
// Command-queue bus: push side, status flags and the SPI transmitter handshake.
// The queue itself connects through the slave modport; the producer and the
// SPI transmitter model connect through the master modport.
interface tft_cmd_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // push side
    logic          wr_en;
    logic [8:0]    wr_data;     // {dc, byte}

    // status
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ack_error;
    logic          idle;

    // SPI transmitter side
    logic          spi_load;
    logic [7:0]    spi_data;
    logic          tft_dc;
    logic          spi_busy;

    modport slave (
        input  wr_en,
        input  wr_data,
        input  spi_busy,
        output full,
        output empty,
        output count,
        output overflow,
        output ack_error,
        output idle,
        output spi_load,
        output spi_data,
        output tft_dc
    );

    modport master (
        output wr_en,
        output wr_data,
        output spi_busy,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  ack_error,
        input  idle,
        input  spi_load,
        input  spi_data,
        input  tft_dc
    );
endinterface

// File: rtl/tft_cmd_queue.sv
// TFT command/data byte queue feeding an SPI byte transmitter.
// Entries are {dc, byte}. The head entry is handed to the transmitter with a
// spi_load request; the block waits for spi_busy as an acknowledge, then for
// spi_busy to fall before sending the next entry. An entry that is never
// acknowledged within ACK_TIMEOUT cycles is dropped and ack_error is latched.
module tft_cmd_queue #(
    parameter int DEPTH       = 16,   // power of two, >= 2
    parameter int ACK_TIMEOUT = 15    // >= 1
) (
    input  logic           clk,
    input  logic           reset,
    tft_cmd_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO_C = {CW{1'b0}};
    localparam logic [TW-1:0] TIMER_LAST_C = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // storage and pointers
    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // registered status
    logic          full_r;
    logic          empty_r;
    logic          overflow_r;
    logic          ack_error_r;
    logic          idle_r;

    // transmitter side
    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          spi_load_r;
    logic [7:0]    spi_data_r;
    logic          tft_dc_r;

    // next-cycle decode
    logic          push_s;
    logic          pop_s;
    logic          timeout_s;
    logic          next_idle_s;
    logic [CW-1:0] count_next_s;
    logic [8:0]    head_s;

    // Push/pop qualification, timeout detect and next count / next-idle decode.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        timeout_s    = 1'b0;
        next_idle_s  = 1'b0;
        count_next_s = count_r;
        head_s       = mem_r[rd_ptr_r];

        // a push against a full queue is refused even if a pop frees a slot
        push_s    = bus.wr_en & ~full_r;
        timeout_s = (state_r == ST_WAIT_ACK) & ~bus.spi_busy & (timer_r == TIMER_LAST_C);

        case (state_r)
            ST_IDLE: begin
                pop_s       = ~empty_r;
                next_idle_s = empty_r;
            end
            ST_WAIT_ACK: begin
                pop_s       = 1'b0;
                next_idle_s = timeout_s;
            end
            ST_WAIT_DONE: begin
                pop_s       = 1'b0;
                next_idle_s = ~bus.spi_busy;
            end
            default: begin
                pop_s       = 1'b0;
                next_idle_s = 1'b1;
            end
        endcase

        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Entry storage; a reset edge never writes so a reset-time push is lost.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and the full/empty/overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= COUNT_ZERO_C;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            // pointers are exactly AW bits wide, so they wrap modulo DEPTH
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == COUNT_ZERO_C);
        end
    end

    // Transmitter handshake FSM with its registered outputs and ack timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TW{1'b0}};
            spi_load_r  <= 1'b0;
            spi_data_r  <= 8'h00;
            tft_dc_r    <= 1'b0;
            ack_error_r <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            idle_r <= next_idle_s & (count_next_s == COUNT_ZERO_C);
            case (state_r)
                ST_IDLE: begin
                    // byte and DC stay on the lines until the next pop
                    if (pop_s) begin
                        spi_data_r <= head_s[7:0];
                        tft_dc_r   <= head_s[8];
                        spi_load_r <= 1'b1;
                        timer_r    <= {TW{1'b0}};
                        state_r    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.spi_busy) begin
                        spi_load_r <= 1'b0;
                        state_r    <= ST_WAIT_DONE;
                    end else if (timeout_s) begin
                        // transmitter never answered: abandon this entry
                        spi_load_r  <= 1'b0;
                        ack_error_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.spi_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    spi_load_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
    assign bus.ack_error = ack_error_r;
    assign bus.idle      = idle_r;
    assign bus.spi_load  = spi_load_r;
    assign bus.spi_data  = spi_data_r;
    assign bus.tft_dc    = tft_dc_r;

endmodule

// File: tb/tb_tft_cmd_queue.sv
// Bench for tft_cmd_queue: scoreboard of pushed entries compared against each
// spi_load rising edge, plus directed status checks around the handshake.
module tb_tft_cmd_queue;

    logic clk;
    logic reset;

    tft_cmd_queue_if #(.DEPTH(16)) bus ();

    tft_cmd_queue #(
        .DEPTH       (16),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] sb_q [$];
    logic [8:0] hold_exp = 9'h000;
    int         load_cnt = 0;

    // busy model controls
    bit busy_on   = 1'b0;
    bit busy_rand = 1'b0;
    int busy_dly  = 1;
    int busy_len  = 8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // SPI transmitter model: answers each load after a delay, busy for a while.
    initial begin : busy_model
        int dly;
        int len;
        bus.spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_on && bus.spi_load === 1'b1) begin
                if (busy_rand) begin
                    dly = $urandom_range(0, 4);
                    len = $urandom_range(1, 6);
                end else begin
                    dly = busy_dly;
                    len = busy_len;
                end
                repeat (dly) @(negedge clk);
                bus.spi_busy = 1'b1;
                repeat (len) @(negedge clk);
                bus.spi_busy = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard on load, hold stability, load drop on busy.
    logic mon_rst;
    logic mon_load;
    logic mon_busy;
    logic [8:0] mon_exp;
    always @(posedge clk) begin
        mon_rst  = reset;
        mon_load = bus.spi_load;
        mon_busy = bus.spi_busy;
        #1;
        if (mon_rst) begin
            hold_exp = 9'h000;
            check_val("rst_load", 32'(bus.spi_load), 32'd0);
            check_val("rst_hold", 32'({bus.tft_dc, bus.spi_data}), 32'(hold_exp));
        end else if (mon_load == 1'b0 && bus.spi_load == 1'b1) begin
            load_cnt++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_load", 32'd1, 32'd0);
            end else begin
                mon_exp  = sb_q.pop_front();
                hold_exp = mon_exp;
                check_val("sb_entry", 32'({bus.tft_dc, bus.spi_data}), 32'(mon_exp));
            end
        end else begin
            check_val("hold", 32'({bus.tft_dc, bus.spi_data}), 32'(hold_exp));
            if (mon_load == 1'b1 && mon_busy == 1'b1) begin
                check_val("load_drop", 32'(bus.spi_load), 32'd0);
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        bus.wr_en  = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (bus.idle !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("idle_wait", 32'(n < bound), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [8:0] d;
        int n;
        int k;
        int loads_at_reset;

        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 9'h000;

        // ---- reset state
        do_reset();
        check_val("rst_spi_load",  32'(bus.spi_load),  32'd0);
        check_val("rst_spi_data",  32'(bus.spi_data),  32'h00);
        check_val("rst_tft_dc",    32'(bus.tft_dc),    32'd0);
        check_val("rst_count",     32'(bus.count),     32'd0);
        check_val("rst_empty",     32'(bus.empty),     32'd1);
        check_val("rst_full",      32'(bus.full),      32'd0);
        check_val("rst_overflow",  32'(bus.overflow),  32'd0);
        check_val("rst_ack_error", 32'(bus.ack_error), 32'd0);
        check_val("rst_idle",      32'(bus.idle),      32'd1);

        // ---- two entries through the handshake, one-edge load latency
        busy_on = 1'b1; busy_rand = 1'b0; busy_dly = 1; busy_len = 8;
        bus.wr_en = 1'b1; bus.wr_data = 9'h036; sb_q.push_back(9'h036);
        @(posedge clk); #1;
        check_val("lat_load_n",  32'(bus.spi_load), 32'd0);
        check_val("lat_count_n", 32'(bus.count),    32'd1);
        check_val("lat_idle_n",  32'(bus.idle),     32'd0);
        bus.wr_data = 9'h148; sb_q.push_back(9'h148);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check_val("lat_load_n1", 32'(bus.spi_load), 32'd1);
        check_val("lat_data_n1", 32'(bus.spi_data), 32'h36);
        check_val("lat_dc_n1",   32'(bus.tft_dc),   32'd0);
        check_val("lat_count_n1",32'(bus.count),    32'd1);
        wait_idle(200);
        check_val("pair_data", 32'(bus.spi_data), 32'h48);
        check_val("pair_dc",   32'(bus.tft_dc),   32'd1);
        check_val("pair_count",32'(bus.count),    32'd0);

        // ---- ack timeout with busy stuck low
        do_reset();
        busy_on = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 9'h0AA; sb_q.push_back(9'h0AA);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        n = 0;
        while (bus.spi_load !== 1'b1 && n < 5) begin
            @(posedge clk); #1; n++;
        end
        check_val("to_latency", 32'(n), 32'd1);
        check_val("to_err_early", 32'(bus.ack_error), 32'd0);
        k = 0;
        while (bus.spi_load === 1'b1 && k < 40) begin
            @(posedge clk); #1; k++;
        end
        check_val("to_load_cycles", 32'(k), 32'd15);
        check_val("to_ack_error", 32'(bus.ack_error), 32'd1);
        check_val("to_idle",      32'(bus.idle),      32'd1);
        check_val("to_count",     32'(bus.count),     32'd0);
        check_val("to_overflow",  32'(bus.overflow),  32'd0);

        // ---- fill to full with busy low; 18th push meets full plus a pop
        do_reset();
        busy_on = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            d = {i[0], 8'(8'h10 + i)};
            bus.wr_en = 1'b1; bus.wr_data = d;
            if (i <= 17) sb_q.push_back(d);
            @(posedge clk); #1;
            if (i == 16) begin
                check_val("fill16_count", 32'(bus.count), 32'd15);
                check_val("fill16_full",  32'(bus.full),  32'd0);
            end
            if (i == 17) begin
                check_val("fill17_count",    32'(bus.count),    32'd16);
                check_val("fill17_full",     32'(bus.full),     32'd1);
                check_val("fill17_overflow", 32'(bus.overflow), 32'd0);
            end
            if (i == 18) begin
                check_val("ovf_count",    32'(bus.count),    32'd15);
                check_val("ovf_overflow", 32'(bus.overflow), 32'd1);
                check_val("ovf_full",     32'(bus.full),     32'd0);
            end
        end
        bus.wr_en = 1'b0;
        busy_on = 1'b1; busy_rand = 1'b1;
        wait_idle(3000);
        check_val("drain_count",    32'(bus.count),     32'd0);
        check_val("drain_empty",    32'(bus.empty),     32'd1);
        check_val("drain_overflow", 32'(bus.overflow),  32'd1);
        check_val("drain_ack_err",  32'(bus.ack_error), 32'd1);
        check_val("drain_sb",       32'(sb_q.size()),   32'd0);

        // ---- 40 random entries in bursts, random busy timing, pointer wrap
        do_reset();
        busy_on = 1'b1; busy_rand = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 8; j++) begin
                d = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
                bus.wr_en = 1'b1; bus.wr_data = d; sb_q.push_back(d);
                @(posedge clk); #1;
            end
            bus.wr_en = 1'b0;
            wait_idle(600);
        end
        check_val("rnd_sb",        32'(sb_q.size()),   32'd0);
        check_val("rnd_count",     32'(bus.count),     32'd0);
        check_val("rnd_overflow",  32'(bus.overflow),  32'd0);
        check_val("rnd_ack_error", 32'(bus.ack_error), 32'd0);

        // ---- reset in WAIT_DONE with 5 entries queued
        do_reset();
        busy_on = 1'b1; busy_rand = 1'b0; busy_dly = 1; busy_len = 20;
        for (int j = 0; j < 6; j++) begin
            d = {1'(j % 2), 8'(8'hC0 + j)};
            bus.wr_en = 1'b1; bus.wr_data = d; sb_q.push_back(d);
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("mid_count",    32'(bus.count),    32'd5);
        check_val("mid_spi_load", 32'(bus.spi_load), 32'd0);
        check_val("mid_idle",     32'(bus.idle),     32'd0);
        loads_at_reset = load_cnt;
        do_reset();
        check_val("mrst_spi_load", 32'(bus.spi_load), 32'd0);
        check_val("mrst_count",    32'(bus.count),    32'd0);
        check_val("mrst_idle",     32'(bus.idle),     32'd1);
        repeat (40) begin @(posedge clk); #1; end
        check_val("mrst_no_loads", 32'(load_cnt), 32'(loads_at_reset));
        check_val("mrst_idle_end", 32'(bus.idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
